// File: rtl/seq_incrementer.sv
// rtl/seq_incrementer.sv - multi-cycle chunked +1/-1 unit with early carry termination
// Ripples the operand CHUNK bits per cycle; stops as soon as the carry/borrow dies.
module seq_incrementer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             dec,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic [IW-1:0]    idx;
  logic             carry, dec_r, sat_r;
  logic [CHUNK:0]   sum;
  logic             leave;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Top bit of sum is the new carry (inc) or borrow (dec) out of this chunk.
  always_comb begin
    if (dec_r)
      sum = {1'b0, work[idx*CHUNK +: CHUNK]} - {{CHUNK{1'b0}}, carry};
    else
      sum = {1'b0, work[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    work_n = work;
    work_n[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    leave = !sum[CHUNK] || (idx == LAST);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (leave)     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      dec_r <= 1'b0;
      sat_r <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= a;
            dec_r <= dec;
            sat_r <= sat;
            carry <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_n;
          carry <= sum[CHUNK];
          idx   <= idx + IW'(1);
          if (leave) begin
            cout <= sum[CHUNK];
            if (sat_r && sum[CHUNK])
              z <= dec_r ? '0 : '1;
            else
              z <= work_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_incrementer.sv
// tb/tb_seq_incrementer.sv - scoreboard bench for seq_incrementer (8/4 and 16/4 configs)
module tb_seq_incrementer;

  typedef struct {
    logic [15:0] z;
    logic        c;
    int          k;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, dec8 = 0, sat8 = 0, ov8, or8 = 0, c8;
  logic [7:0] a8 = 0, z8;
  logic        iv16 = 0, ir16, ov16, or16 = 0, c16;
  logic [15:0] a16 = 0, z16;

  seq_incrementer #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .dec(dec8),
    .sat(sat8), .out_valid(ov8), .out_ready(or8), .z(z8), .cout(c8));

  seq_incrementer #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .dec(1'b0),
    .sat(1'b0), .out_valid(ov16), .out_ready(or16), .z(z16), .cout(c16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole-width reference: k counts low chunks that propagate the carry/borrow.
  function automatic exp_t model(input logic [7:0] av, input logic d, input logic s);
    exp_t m;
    logic [8:0] f;
    logic [3:0] pass;
    f = d ? ({1'b0, av} - 9'd1) : ({1'b0, av} + 9'd1);
    m.c = f[8];
    m.z = (s && f[8]) ? (d ? 16'h0000 : 16'h00FF) : {8'h00, f[7:0]};
    pass = d ? 4'h0 : 4'hF;
    m.k = (av[3:0] == pass) ? 2 : 1;
    return m;
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic d,
                        input logic s, input exp_t e, input bit release_out);
    exp_t got;
    int cyc;
    sb.push_back(e);
    a8 = av; dec8 = d; sat8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk({tag, "_busy"}, 32'(ir8), 32'd0);
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_valid"}, 32'(ov8), 32'd1);
    got = sb.pop_front();
    chk({tag, "_z"}, 32'(z8), 32'(got.z));
    chk({tag, "_cout"}, 32'(c8), 32'(got.c));
    chk({tag, "_k"}, 32'(cyc), 32'(got.k));
    if (release_out) begin
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk({tag, "_idle"}, 32'(ir8), 32'd1);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] zv, input logic cv, input int kv);
    exp_t m;
    m.z = zv; m.c = cv; m.k = kv;
    return m;
  endfunction

  initial begin
    logic [7:0] ra;
    logic rd, rs;
    int cyc;
    #2;
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_z", 32'(z8), 32'd0);
    chk("rst_cout", 32'(c8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("inc00",   8'h00, 0, 0, mk(16'h01, 0, 1), 1);
    run_op("inc0f",   8'h0F, 0, 0, mk(16'h10, 0, 2), 1);
    run_op("inc3a",   8'h3A, 0, 0, mk(16'h3B, 0, 1), 1);
    run_op("incff",   8'hFF, 0, 0, mk(16'h00, 1, 2), 1);
    run_op("incff_s", 8'hFF, 0, 1, mk(16'hFF, 1, 2), 1);
    run_op("dec10",   8'h10, 1, 0, mk(16'h0F, 0, 2), 1);
    run_op("dec00",   8'h00, 1, 0, mk(16'hFF, 1, 2), 1);
    run_op("dec00_s", 8'h00, 1, 1, mk(16'h00, 1, 2), 1);

    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      if (i % 3 == 0) ra[3:0] = (i % 2 == 0) ? 4'hF : 4'h0;
      rd = 1'($urandom);
      rs = 1'($urandom);
      run_op("rand", ra, rd, rs, model(ra, rd, rs), 1);
    end

    // Back-pressure: result must hold while in_valid pulses are ignored.
    run_op("bp", 8'h00, 0, 0, mk(16'h01, 0, 1), 0);
    for (int i = 0; i < 5; i++) begin
      iv8 = (i % 2 == 0);
      a8 = 8'h55;
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(ov8), 32'd1);
      chk("bp_hold_z", 32'(z8), 32'h01);
      chk("bp_hold_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("bp_rel_ready", 32'(ir8), 32'd1);
    chk("bp_rel_valid", 32'(ov8), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_ghost", 32'(ir8), 32'd1);

    // 16-bit: reset asserted mid-RUN discards the operation.
    a16 = 16'h0FFF; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("w16_rst_ready", 32'(ir16), 32'd1);
    chk("w16_rst_valid", 32'(ov16), 32'd0);
    chk("w16_rst_z", 32'(z16), 32'd0);
    chk("w16_rst_cout", 32'(c16), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("w16_no_out", 32'(ov16), 32'd0);
    end

    sb.push_back(mk(16'h1000, 0, 4));
    iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    cyc = 0;
    while (!ov16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w16_valid", 32'(ov16), 32'd1);
    begin
      exp_t e;
      e = sb.pop_front();
      chk("w16_z", 32'(z16), 32'(e.z));
      chk("w16_cout", 32'(c16), 32'(e.c));
      chk("w16_k", 32'(cyc), 32'(e.k));
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("w16_idle", 32'(ir16), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
